// File: rtl/booth_mult_pipe_hs_if.sv
// booth_mult_pipe_hs_if: ready/valid operand channel and product channel of the Booth multiplier.
interface booth_mult_pipe_hs_if #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   multiplicand;
    logic [WIDTH-1:0]   multiplier;
    logic [1:0]         sign_mode;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] product;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, multiplicand, multiplier, sign_mode, in_tag, out_ready,
        input  in_ready, out_valid, product, out_tag
    );

    modport slave (
        input  in_valid, multiplicand, multiplier, sign_mode, in_tag, out_ready,
        output in_ready, out_valid, product, out_tag
    );
endinterface

// File: rtl/booth_mult_pipe_hs.sv
// booth_mult_pipe_hs: 4-stage radix-4 Booth multiplier with ready/valid backpressure and tag sideband.
module booth_mult_pipe_hs #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    booth_mult_pipe_hs_if.slave bus
);
    localparam int OP_W  = WIDTH + 2;
    localparam int NPP   = WIDTH / 2 + 1;
    localparam int SUM_W = 2 * WIDTH + 8;

    if (WIDTH % 2 != 0 || WIDTH < 4) begin : g_bad_width
        $error("booth_mult_pipe_hs: WIDTH must be even and >= 4");
    end

    logic                      en;
    logic [3:0]                v_q;
    logic [WIDTH-1:0]          a1_q, b1_q;
    logic [1:0]                sm1_q;
    logic [TAG_W-1:0]          tag1_q, tag2_q, tag3_q, tag4_q;
    logic [NPP-1:0][3:0]       sel_q, sel_d;
    logic [NPP-1:0]            neg_q, neg_d;
    logic [OP_W-1:0]           a_ext, b_ext, ap_q, an_q, a2p_q, a2n_q, pick;
    logic [OP_W:0]             bx;
    logic [NPP-1:0][SUM_W-1:0] pp_q, pp_d;
    logic [SUM_W-1:0]          corr_q, corr_d, total;
    logic [2*WIDTH-1:0]        prod_q;
    logic                      unused_hi;

    // One enable for the whole pipe: a stalled output freezes every stage.
    assign en            = !v_q[3] || bus.out_ready;
    assign bus.in_ready  = en;
    assign bus.out_valid = v_q[3];
    assign bus.product   = prod_q;
    assign bus.out_tag   = tag4_q;

    assign a_ext = {{2{sm1_q[1] & a1_q[WIDTH-1]}}, a1_q};
    assign b_ext = {{2{sm1_q[0] & b1_q[WIDTH-1]}}, b1_q};
    assign bx    = {b_ext, 1'b0};

    // Select bits per group: [0]=+A, [1]=-A, [2]=+2A, [3]=-2A.
    always_comb begin
        sel_d = '0;
        neg_d = '0;
        for (int k = 0; k < NPP; k++) begin
            sel_d[k][0] = bx[2*k+:3] == 3'b001 || bx[2*k+:3] == 3'b010;
            sel_d[k][1] = bx[2*k+:3] == 3'b101 || bx[2*k+:3] == 3'b110;
            sel_d[k][2] = bx[2*k+:3] == 3'b011;
            sel_d[k][3] = bx[2*k+:3] == 3'b100;
            neg_d[k]    = sel_d[k][1] | sel_d[k][3];
        end
    end

    // Negative digits use the inverted vector; their +1 lands in corr_d at the group's weight.
    always_comb begin
        pp_d   = '0;
        corr_d = '0;
        pick   = '0;
        for (int k = 0; k < NPP; k++) begin
            pick = ({OP_W{sel_q[k][0]}} & ap_q) | ({OP_W{sel_q[k][1]}} & an_q) |
                   ({OP_W{sel_q[k][2]}} & a2p_q) | ({OP_W{sel_q[k][3]}} & a2n_q);
            pp_d[k]       = {{(SUM_W-OP_W){pick[OP_W-1]}}, pick} << (2 * k);
            corr_d[2*k]   = neg_q[k];
        end
    end

    always_comb begin
        total = corr_q;
        for (int k = 0; k < NPP; k++) total = total + pp_q[k];
    end

    assign unused_hi = ^total[SUM_W-1:2*WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            a1_q   <= '0;
            b1_q   <= '0;
            sm1_q  <= '0;
            tag1_q <= '0;
            sel_q  <= '0;
            neg_q  <= '0;
            ap_q   <= '0;
            an_q   <= '0;
            a2p_q  <= '0;
            a2n_q  <= '0;
            tag2_q <= '0;
            pp_q   <= '0;
            corr_q <= '0;
            tag3_q <= '0;
            prod_q <= '0;
            tag4_q <= '0;
        end else if (en) begin
            v_q    <= {v_q[2:0], bus.in_valid};
            a1_q   <= bus.multiplicand;
            b1_q   <= bus.multiplier;
            sm1_q  <= bus.sign_mode;
            tag1_q <= bus.in_tag;
            sel_q  <= sel_d;
            neg_q  <= neg_d;
            ap_q   <= a_ext;
            an_q   <= ~a_ext;
            a2p_q  <= {a_ext[OP_W-2:0], 1'b0};
            a2n_q  <= ~{a_ext[OP_W-2:0], 1'b0};
            tag2_q <= tag1_q;
            pp_q   <= pp_d;
            corr_q <= corr_d;
            tag3_q <= tag2_q;
            prod_q <= total[2*WIDTH-1:0];
            tag4_q <= tag3_q;
        end
    end
endmodule

// File: tb/tb_booth_mult_pipe_hs.sv
// tb_booth_mult_pipe_hs: directed corners, backpressure, bubbles and reset on WIDTH=8,
// random traffic with scoreboards on WIDTH=16.
module tb_booth_mult_pipe_hs;
    localparam int NR = 10000;

    logic clk, rst_n;
    int   checks = 0, errors = 0;
    int   got8 = 0, bp_base, i8, n16, stale;
    logic stall_prev, hold16;
    logic [15:0] hold_p;
    logic [3:0]  hold_t, pat;
    logic [15:0] q8_p[$];
    logic [3:0]  q8_t[$];
    logic [31:0] q16_p[$];
    logic [5:0]  q16_t[$];

    booth_mult_pipe_hs_if #(.WIDTH(8), .TAG_W(4)) b8();
    booth_mult_pipe_hs_if #(.WIDTH(16), .TAG_W(6)) b16();

    booth_mult_pipe_hs #(.WIDTH(8), .TAG_W(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
    booth_mult_pipe_hs #(.WIDTH(16), .TAG_W(6)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Exact product from the operand values the sign modes describe, truncated to 2*w bits.
    function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a, input logic [15:0] b,
                                            input logic [1:0] sm);
        longint x, y;
        x = longint'(a);
        y = longint'(b);
        if (sm[1] && a[w-1]) x = x - (longint'(1) << w);
        if (sm[0] && b[w-1]) y = y - (longint'(1) << w);
        return 32'((x * y) & ((longint'(1) << (2 * w)) - 1));
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q8_p.delete();
            q8_t.delete();
        end else begin
            if (b8.in_valid && b8.in_ready) begin
                q8_p.push_back(16'(ref_mul(8, 16'(b8.multiplicand), 16'(b8.multiplier), b8.sign_mode)));
                q8_t.push_back(b8.in_tag);
            end
            if (b8.out_valid && b8.out_ready) begin
                got8++;
                if (q8_p.size() == 0) check("sb8_extra", 1, 0);
                else begin
                    check("sb8_p", b8.product, q8_p.pop_front());
                    check("sb8_t", b8.out_tag, q8_t.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q16_p.delete();
            q16_t.delete();
        end else begin
            if (b16.in_valid && b16.in_ready) begin
                q16_p.push_back(ref_mul(16, b16.multiplicand, b16.multiplier, b16.sign_mode));
                q16_t.push_back(b16.in_tag);
            end
            if (b16.out_valid && b16.out_ready) begin
                if (q16_p.size() == 0) check("sb16_extra", 1, 0);
                else begin
                    check("sb16_p", b16.product, q16_p.pop_front());
                    check("sb16_t", b16.out_tag, q16_t.pop_front());
                end
            end
        end
    end

    task automatic one8(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] sm, input logic [15:0] exp);
        b8.in_valid     = 1;
        b8.multiplicand = a;
        b8.multiplier   = b;
        b8.sign_mode    = sm;
        b8.in_tag       = 4'hA;
        @(posedge clk); #1;
        b8.in_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({nm, "_early"}, b8.out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check({nm, "_v"}, b8.out_valid, 1);
        check(nm, b8.product, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        clk = 0;
        rst_n = 0;
        {b8.in_valid, b8.multiplicand, b8.multiplier, b8.sign_mode, b8.in_tag} = '0;
        {b16.in_valid, b16.multiplicand, b16.multiplier, b16.sign_mode, b16.in_tag} = '0;
        b8.out_ready = 1;
        b16.out_ready = 1;
        @(negedge clk);
        check("rst_v8", b8.out_valid, 0);
        check("rst_p8", b8.product, 0);
        check("rst_t8", b8.out_tag, 0);
        check("rst_v16", b16.out_valid, 0);
        check("rst_p16", b16.product, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        check("rst_rdy8", b8.in_ready, 1);
        @(posedge clk); #1;

        one8("s_mm", 8'h80, 8'h80, 2'b11, 16'h4000);
        one8("s_mp", 8'h80, 8'h7F, 2'b11, 16'hC080);
        one8("s_zn", 8'h00, 8'hFF, 2'b11, 16'h0000);
        one8("u_max", 8'hFF, 8'hFF, 2'b00, 16'hFE01);
        one8("su", 8'hFF, 8'hFF, 2'b10, 16'hFF01);
        one8("us", 8'hFF, 8'hFF, 2'b01, 16'hFF01);

        // Backpressure: ten tagged i*3 transactions, consumer stalls for cycles 6..10.
        bp_base = got8;
        i8 = 0;
        stall_prev = 0;
        for (int c = 0; c < 80 && got8 - bp_base < 10; c++) begin
            b8.out_ready    = !(c >= 6 && c <= 10);
            b8.in_valid     = i8 < 10;
            b8.multiplicand = 8'(i8);
            b8.multiplier   = 8'd3;
            b8.sign_mode    = 2'b00;
            b8.in_tag       = 4'(i8);
            @(negedge clk);
            if (b8.out_valid && !b8.out_ready) check("bp_inrdy", b8.in_ready, 0);
            if (stall_prev) begin
                check("bp_hold_p", b8.product, hold_p);
                check("bp_hold_t", b8.out_tag, hold_t);
            end
            stall_prev = b8.out_valid && !b8.out_ready;
            hold_p = b8.product;
            hold_t = b8.out_tag;
            if (b8.in_valid && b8.in_ready) i8++;
            @(posedge clk); #1;
        end
        check("bp_count", got8 - bp_base, 10);
        b8.in_valid  = 0;
        b8.out_ready = 1;

        pat = 4'b1001;
        for (int c = 0; c < 8; c++) begin
            b8.in_valid     = c < 4 ? pat[c] : 1'b0;
            b8.multiplicand = 8'($urandom);
            b8.multiplier   = 8'($urandom);
            b8.sign_mode    = 2'($urandom);
            b8.in_tag       = 4'(c);
            @(negedge clk);
            if (c >= 4) check("bubble_v", b8.out_valid, pat[c-4]);
            @(posedge clk); #1;
        end
        b8.in_valid = 0;

        // Reset while three transactions are in flight and the first is on the output.
        for (int c = 0; c < 3; c++) begin
            b8.in_valid     = 1;
            b8.multiplicand = 8'($urandom) | 8'h11;
            b8.multiplier   = 8'($urandom) | 8'h11;
            b8.sign_mode    = 2'b00;
            b8.in_tag       = 4'(c + 1);
            @(posedge clk); #1;
        end
        b8.in_valid = 0;
        @(posedge clk); #1;
        rst_n = 0;
        #2;
        check("rst_mid_v", b8.out_valid, 0);
        check("rst_mid_p", b8.product, 0);
        check("rst_mid_t", b8.out_tag, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1;
        stale = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (b8.out_valid) stale++;
        end
        check("rst_stale", stale, 0);
        @(posedge clk); #1;

        n16 = 0;
        hold16 = 0;
        for (int c = 0; c < 40000 && n16 < NR; c++) begin
            b16.out_ready = $urandom_range(3) != 0;
            if (!hold16) begin
                b16.in_valid     = n16 < 2 || $urandom_range(4) != 0;
                b16.sign_mode    = 2'($urandom);
                b16.multiplicand = $urandom_range(7) == 0 ? 16'h8000 : 16'($urandom);
                b16.multiplier   = $urandom_range(7) == 0 ? 16'hFFFF : 16'($urandom);
                if (n16 == 0) {b16.multiplicand, b16.multiplier, b16.sign_mode} = {16'h8000, 16'h8000, 2'b11};
                if (n16 == 1) {b16.multiplicand, b16.multiplier, b16.sign_mode} = {16'hFFFF, 16'hFFFF, 2'b00};
                b16.in_tag = 6'(n16);
            end
            @(negedge clk);
            hold16 = b16.in_valid && !b16.in_ready;
            if (b16.in_valid && b16.in_ready) n16++;
            @(posedge clk); #1;
        end
        b16.in_valid  = 0;
        b16.out_ready = 1;
        for (int c = 0; c < 50 && q16_p.size() != 0; c++) @(posedge clk);
        #1;
        check("n16", n16, NR);
        check("drain16", q16_p.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/booth_mult_pipe_hs.md
Name: booth_mult_pipe_hs

Overview:
- Parametrised radix-4 Booth pipelined multiplier; next generation of the 8-bit fixed-width multiplier.
- Adds generic WIDTH, valid/ready backpressure and a per-transaction tag that travels with the operands.
- Keeps the per-transaction sign_mode and the invert-and-add negation (the +1 for each negative partial product is summed through a correction vector).
- Sits between a ready/valid producer (DSP datapath) and a consumer that may stall.

Parameters:
- WIDTH, 8, operand width; must be even and >= 4 (elaboration error otherwise).
- TAG_W, 4, width of the sideband tag carried with each transaction.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  block can accept this cycle.
- multiplicand  in  WIDTH  operand A.
- multiplier  in  WIDTH  operand B.
- sign_mode  in  2  bit 1 = A is signed, bit 0 = B is signed.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts the product.
- product  out  2*WIDTH  A*B, two's complement if either operand is signed.
- out_tag  out  TAG_W  tag of the product's transaction.

Behaviour:
- Reset: all stage valid bits = 0; out_valid = 0; product = 0; out_tag = 0; all data registers = 0. Reset mid-operation discards every in-flight transaction; no output appears after rst_n deasserts until new input is accepted.
- Global advance enable: en = !out_valid || out_ready. in_ready = en (combinational from out_ready; documented path). Accept occurs when in_valid && in_ready.
- All pipeline registers, valid bits included, load only when en = 1. When en = 0, everything holds and product/out_tag stay stable. Bubbles are not compressed.
- S1, input register: OP_W = WIDTH+2. Each operand is extended by 2 bits, sign-extended if its sign_mode bit is 1, zero-extended otherwise. sign_mode and tag are registered here.
- S2, encode and precompute:
  - NPP = WIDTH/2+1 groups taken from {B_ext, 1'b0}; group k uses bits [2k+2:2k].
  - Booth digit per group: 000/111 → 0; 001/010 → +A; 011 → +2A; 100 → −2A; 101/110 → −A.
  - Register one-hot selects (+1, −1, +2, −2) and neg[k] = (digit is −A or −2A).
  - Register A, ~A, 2A and ~(2A) at OP_W width.
- S3, select: PP_k = AND-OR of the selected vector (0 if no select active), sign-extended to SUM_W = 2*WIDTH+8, then shifted left by 2k. correction = OR of (neg[k] << 2k).
- S4, sum: total = sum of all PP_k + correction, computed modulo 2^SUM_W. product <= total[2*WIDTH-1:0]; out_tag <= tag; out_valid <= S3 valid.
- Latency: 4 en-cycles from accept to out_valid. With out_ready held at 1: throughput 1 per cycle, and product appears exactly 4 clocks after accept.
- Output handshake: the transaction retires on out_valid && out_ready. The next pipeline entry loads in the same edge; there is no gap when it is valid.
- Unsigned × unsigned max (2^WIDTH−1)^2 fits in 2*WIDTH bits. Signed −2^(WIDTH−1) × −2^(WIDTH−1) = 2^(2*WIDTH−2) is representable. Mixed modes give the exact two's-complement result truncated to 2*WIDTH bits.
- Transactions and tags leave in acceptance order; none dropped, none duplicated.
- in_valid while in_ready = 0: the input is ignored; the producer must hold it (standard ready/valid).

Test Plan:
- Corners, WIDTH=8, sign_mode=11: A=−128, B=−128 → product 0x4000. A=−128, B=127 → 0xC080. A=0, B=−1 → 0x0000. Each appears 4 cycles after accept.
- Unsigned and mixed, WIDTH=8: sign_mode=00, 255×255 → 0xFE01. sign_mode=10, A=0xFF (−1), B=255 → 0xFF01. sign_mode=01, A=255, B=0xFF (−1) → 0xFF01.
- Backpressure: stream 10 tagged transactions (tags 0..9, A=i, B=3, unsigned) with out_ready low for cycles 6–10.
  - in_ready falls the same cycle out_valid && !out_ready.
  - product/out_tag hold stable while stalled.
  - All 10 products 3*i arrive in tag order, none lost.
- Reset mid-flight: accept 3 transactions, assert rst_n low 1 cycle later → out_valid = 0, product = 0, out_tag = 0 immediately. No stale result appears afterwards.
- Bubbles: in_valid pattern 1,0,0,1 with out_ready = 1 → out_valid pattern 1,0,0,1 starting 4 cycles after the first accept.
- WIDTH=16, TAG_W=6: 10k random operands, all 4 sign modes, random out_ready → scoreboard matches the golden product [31:0] and tag order. Also check 0x8000×0x8000 signed → 0x40000000 and 0xFFFF×0xFFFF unsigned → 0xFFFE0001.
